// File: rtl/rom_boot_copier.sv
// Copies COUNT 16-bit words from a synchronous ROM to a Wishbone slave, then releases the core reset.
// Optional running checksum of acknowledged words is enabled by defining ROM_BOOT_CHECKSUM_EN.
module rom_boot_copier #(
  parameter int          SIZE       = 'h2000,
  parameter int          ADDR_WIDTH = $clog2(SIZE),
  parameter int          DATA_WIDTH = 16,
  parameter int          COUNT      = SIZE,
  parameter logic [31:0] BASE_ADR   = 32'h0,
  parameter bit          AUTOSTART  = 1'b1
) (
  input  logic                    clock,
  input  logic                    resetq,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  output logic                    rom_cen,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [31:0]             wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    core_resetq,
  output logic [15:0]             checksum,
  output logic [2:0]              o_dbg_state
);

  // Wishbone handshake: cyc/stb/we rise together on entry to WRITE and hold, with address and
  // data, until ack or err is sampled; err wins when both are high, and either ends the cycle.
  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE, ERROR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(COUNT - 1);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_autostart;
  logic [ADDR_WIDTH-1:0]   r_rom_address;
  logic                    r_rom_cen;
  logic                    r_wb_cyc;
  logic [31:0]             r_wb_adr;
  logic [DATA_WIDTH-1:0]   r_wb_dat;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;
  logic                    r_core_resetq;

  logic                    w_restart;
  logic [ADDR_WIDTH-1:0]   w_idx_next;

  assign w_restart  = ((r_state == IDLE) && (start || r_autostart)) ||
                      (((r_state == DONE) || (r_state == ERROR)) && start);
  assign w_idx_next = r_idx + ADDR_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (!resetq) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_autostart   <= AUTOSTART;
      r_rom_address <= '0;
      r_rom_cen     <= 1'b0;
      r_wb_cyc      <= 1'b0;
      r_wb_adr      <= BASE_ADR;
      r_wb_dat      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_core_resetq <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_restart) begin
            r_autostart   <= 1'b0;
            r_idx         <= '0;
            r_rom_address <= '0;
            r_rom_cen     <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_core_resetq <= 1'b0;
            r_state       <= READ;
          end
        end
        READ: begin
          r_rom_cen <= 1'b0;
          r_state   <= LATCH;
        end
        LATCH: begin
          r_wb_dat <= rom_q;
          r_wb_adr <= BASE_ADR + (32'(r_idx) << 1);
          r_wb_cyc <= 1'b1;
          r_state  <= WRITE;
        end
        WRITE: begin
          if (wb_err_i) begin
            r_wb_cyc <= 1'b0;
            r_busy   <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= ERROR;
          end else if (wb_ack_i) begin
            r_wb_cyc <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_core_resetq <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_idx         <= w_idx_next;
              r_rom_address <= w_idx_next;
              r_rom_cen     <= 1'b1;
              r_state       <= READ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROM_BOOT_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clock) begin
    if (!resetq) begin
      r_checksum <= '0;
    end else if (w_restart) begin
      r_checksum <= '0;
    end else if ((r_state == WRITE) && wb_ack_i && !wb_err_i) begin
      r_checksum <= r_checksum + 16'(r_wb_dat);
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 16'h0;
`endif

  assign rom_address = r_rom_address;
  assign rom_cen     = r_rom_cen;
  assign wb_cyc_o    = r_wb_cyc;
  assign wb_stb_o    = r_wb_cyc;
  assign wb_we_o     = r_wb_cyc;
  assign wb_adr_o    = r_wb_adr;
  assign wb_dat_o    = r_wb_dat;
  assign wb_sel_o    = '1;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign core_resetq = r_core_resetq;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rom_boot_copier.sv
// Bench for rom_boot_copier: a 4-word copier driven by a directed table, random runs and
// hand-written reset sequences, plus an 8-word copier with a non-zero base address.
module tb_rom_boot_copier;

  localparam int          A_COUNT = 4;
  localparam logic [31:0] A_BASE  = 32'h0;
  localparam int          B_COUNT = 8;
  localparam logic [31:0] B_BASE  = 32'h1000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance A: SIZE=16, COUNT=4
  logic        a_resetq, a_start, a_rom_cen, a_cyc, a_stb, a_we, a_ack, a_err;
  logic        a_busy, a_done, a_error, a_core_resetq, a_stray;
  logic [3:0]  a_rom_address;
  logic [15:0] a_rom_q, a_dat, a_checksum;
  logic [31:0] a_adr;
  logic [1:0]  a_sel;
  logic [2:0]  a_dbg;

  // instance B: SIZE=COUNT=8, BASE_ADR=0x1000
  logic        b_resetq, b_start, b_rom_cen, b_cyc, b_stb, b_we, b_ack, b_err;
  logic        b_busy, b_done, b_error, b_core_resetq;
  logic [2:0]  b_rom_address;
  logic [15:0] b_rom_q, b_dat, b_checksum;
  logic [31:0] b_adr;
  logic [1:0]  b_sel;
  logic [2:0]  b_dbg;

  rom_boot_copier #(.SIZE(16), .COUNT(A_COUNT), .BASE_ADR(A_BASE), .AUTOSTART(1'b1)) u_dut_a (
    .clock(clock), .resetq(a_resetq), .start(a_start),
    .rom_address(a_rom_address), .rom_cen(a_rom_cen), .rom_q(a_rom_q),
    .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_we_o(a_we), .wb_adr_o(a_adr),
    .wb_dat_o(a_dat), .wb_sel_o(a_sel), .wb_ack_i(a_ack), .wb_err_i(a_err),
    .busy(a_busy), .done(a_done), .error(a_error), .core_resetq(a_core_resetq),
    .checksum(a_checksum), .o_dbg_state(a_dbg)
  );

  rom_boot_copier #(.SIZE(8), .COUNT(B_COUNT), .BASE_ADR(B_BASE), .AUTOSTART(1'b1)) u_dut_b (
    .clock(clock), .resetq(b_resetq), .start(b_start),
    .rom_address(b_rom_address), .rom_cen(b_rom_cen), .rom_q(b_rom_q),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_adr_o(b_adr),
    .wb_dat_o(b_dat), .wb_sel_o(b_sel), .wb_ack_i(b_ack), .wb_err_i(b_err),
    .busy(b_busy), .done(b_done), .error(b_error), .core_resetq(b_core_resetq),
    .checksum(b_checksum), .o_dbg_state(b_dbg)
  );

  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];
  logic [47:0] got_b[$];
  logic [15:0] mem_a[16];
  logic [15:0] mem_b[8];
  int          dly_of[16];
  int          err_at;
  int          wait_cnt;
  int          rom_exp_idx;
  int          b_rd;
  logic [15:0] exp_sum;
  logic        prev_pending;
  logic [47:0] hold_v;
  int          words, mcyc;

  typedef struct {
    bit use_start;
    int dly_word;
    int dly;
    int err_word;
    int busy_start_at;
    int exp_cycles;
    bit exp_done;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ROM models: data one cycle after the read enable
  always @(posedge clock) if (a_rom_cen) a_rom_q <= mem_a[a_rom_address];
  always @(posedge clock) if (b_rom_cen) b_rom_q <= mem_b[b_rom_address];

  // slave A: per-word wait states; an erroring word raises err together with ack
  always @(posedge clock) begin
    if (!(a_cyc && a_stb) || a_ack || a_err) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    a_ack = a_stray;
    a_err = 1'b0;
    if (a_cyc && a_stb && (wait_cnt >= dly_of[a_adr[4:1]])) begin
      a_ack = 1'b1;
      if (err_at == int'(a_adr[4:1])) a_err = 1'b1;
    end
  end

  assign b_ack   = b_cyc & b_stb;
  assign b_err   = 1'b0;
  assign b_start = 1'b0;

  // monitor A: ROM read order, no read during a bus cycle, stable bus, expected write queue
  always @(negedge clock) begin
    if (!a_resetq) begin
      prev_pending = 1'b0;
    end else begin
      if (a_rom_cen) begin
        chk("rom_addr", 64'(a_rom_address), 64'(rom_exp_idx));
        chk("rom_during_stb", 64'(a_stb), 64'd0);
        rom_exp_idx++;
      end
      if (a_cyc && a_stb) begin
        if (prev_pending) chk("bus_hold", 64'({a_adr, a_dat}), 64'(hold_v));
        hold_v       = {a_adr, a_dat};
        prev_pending = !(a_ack || a_err);
        if (a_ack || a_err) begin
          chk("we_sel", 64'({a_we, a_sel}), 64'({1'b1, 2'b11}));
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got adr=%0h dat=%0h exp=none", a_adr, a_dat);
          end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            if ({a_adr, a_dat} !== e) begin
              errors++;
              $display("FAIL write got=%0h exp=%0h at %0t", {a_adr, a_dat}, e, $time);
            end
          end
        end
      end else begin
        prev_pending = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (b_resetq) begin
      if (b_rom_cen) b_rd++;
      if (b_cyc && b_stb && b_ack) got_b.push_back({b_adr, b_dat});
    end
  end

  task automatic cfg_directed(input int dword, input int dly, input int eword);
    for (int i = 0; i < 16; i++) begin
      mem_a[i]  = 16'h0;
      dly_of[i] = 0;
    end
    mem_a[0] = 16'h1234;
    mem_a[1] = 16'hABCD;
    mem_a[2] = 16'h0000;
    mem_a[3] = 16'hFFFF;
    if (dword >= 0) dly_of[dword] = dly;
    err_at = eword;
  endtask

  // reference: one write per word up to the erroring word, each costing 3 cycles plus its waits
  task automatic build_model(output int cyc, output int nw);
    exp_q.delete();
    rom_exp_idx = 0;
    cyc         = 0;
    nw          = 0;
    exp_sum     = 16'h0;
    for (int i = 0; i < A_COUNT; i++) begin
      exp_q.push_back({A_BASE + 32'(2 * i), mem_a[i]});
      cyc += 3 + dly_of[i];
      nw++;
      if (err_at == i) break;
      exp_sum = exp_sum + mem_a[i];
    end
`ifndef ROM_BOOT_CHECKSUM_EN
    exp_sum = 16'h0;
`endif
  endtask

  task automatic run_and_check(input string name, input int exp_cycles, input bit exp_done,
                               input int nw, input int busy_start_at, input int stray_at);
    int n = 0;
    chk({name, "_busy_rise"}, 64'(a_busy), 64'd1);
    while (!(a_done || a_error) && (n < 300)) begin
      a_start = (n == busy_start_at);
      a_stray = (n == stray_at);
      @(negedge clock);
      n++;
    end
    a_start = 1'b0;
    a_stray = 1'b0;
    chk({name, "_cycles"}, 64'(n), 64'(exp_cycles));
    chk({name, "_status"}, 64'({a_busy, a_done, a_error, a_core_resetq}),
        64'({1'b0, exp_done, !exp_done, exp_done}));
    if (exp_done) chk({name, "_checksum"}, 64'(a_checksum), 64'(exp_sum));
    chk({name, "_rom_reads"}, 64'(rom_exp_idx), 64'(nw));
    chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clock);
    chk({name, "_state_held"}, 64'({a_done, a_error, a_core_resetq}),
        64'({exp_done, !exp_done, exp_done}));
  endtask

  initial begin
    a_resetq = 1'b0;
    b_resetq = 1'b0;
    a_start  = 1'b0;
    a_stray  = 1'b0;
    b_rd     = 0;
    for (int i = 0; i < B_COUNT; i++) mem_b[i] = 16'($urandom);
    cfg_directed(-1, 0, -1);

    vecs[0] = '{0, -1, 0, -1, -1, 12, 1};  // autostart, zero-wait
    vecs[1] = '{1,  1, 3, -1, -1, 15, 1};  // 3 wait states on word 1
    vecs[2] = '{1, -1, 0,  2, -1,  9, 0};  // err (with ack) on word 2
    vecs[3] = '{1, -1, 0, -1, -1, 12, 1};  // restart from ERROR
    vecs[4] = '{1, -1, 0, -1,  4, 12, 1};  // start pulsed while busy
    vecs[5] = '{1,  3, 1, -1, -1, 13, 1};  // 1 wait state on the last word

    repeat (3) @(negedge clock);
    chk("a_reset_ctl", 64'({a_rom_cen, a_rom_address, a_cyc, a_stb, a_we, a_sel,
                            a_busy, a_done, a_error, a_core_resetq}),
        64'({1'b0, 4'h0, 3'b000, 2'b11, 4'b0000}));
    chk("a_reset_data", 64'({a_adr, a_dat, a_checksum}), 64'({A_BASE, 16'h0, 16'h0}));

    for (int v = 0; v < 6; v++) begin
      cfg_directed(vecs[v].dly_word, vecs[v].dly, vecs[v].err_word);
      build_model(mcyc, words);
      if (vecs[v].use_start) begin
        a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
      end else begin
        a_resetq = 1'b1;
        @(negedge clock);
      end
      run_and_check($sformatf("vec%0d", v), vecs[v].exp_cycles, vecs[v].exp_done, words,
                    vecs[v].busy_start_at, -1);
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i]  = 16'($urandom);
        dly_of[i] = int'($urandom_range(0, 3));
      end
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      build_model(mcyc, words);
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
      run_and_check($sformatf("rnd%0d", r), mcyc, err_at < 0, words, -1, -1);
    end

    // reset pulse while word 1 is waiting for ack, then a stray ack during the restart
    begin
      int n = 0;
      cfg_directed(1, 3, -1);
      build_model(mcyc, words);
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
      while (!(a_stb && (a_adr == A_BASE + 32'h2)) && (n < 40)) begin
        @(negedge clock);
        n++;
      end
      chk("rst_reach_word1", 64'(a_stb && (a_adr == A_BASE + 32'h2)), 64'd1);
      @(negedge clock);
      a_resetq = 1'b0;
      @(negedge clock);
      chk("rst_cyc_drop", 64'({a_cyc, a_stb, a_busy, a_core_resetq}), 64'd0);
      a_resetq = 1'b1;
      cfg_directed(-1, 0, -1);
      build_model(mcyc, words);
      @(negedge clock);
      run_and_check("rst_restart", 12, 1'b1, words, -1, 0);
    end

    // 8-word copy at base 0x1000
    begin
      int n = 0;
      chk("b_reset_ctl", 64'({b_rom_cen, b_rom_address, b_cyc, b_sel, b_busy, b_done,
                              b_error, b_core_resetq}),
          64'({1'b0, 3'h0, 1'b0, 2'b11, 4'b0000}));
      chk("b_reset_data", 64'({b_adr, b_dat, b_checksum}), 64'({B_BASE, 16'h0, 16'h0}));
      b_resetq = 1'b1;
      while (!b_done && (n < 100)) begin
        @(negedge clock);
        n++;
      end
      chk("b_cycles", 64'(n), 64'(1 + 3 * B_COUNT));
      chk("b_done", 64'({b_done, b_core_resetq, b_error}), 64'({1'b1, 1'b1, 1'b0}));
      chk("b_write_count", 64'(got_b.size()), 64'(B_COUNT));
      for (int i = 0; i < B_COUNT; i++) begin
        if (i < got_b.size())
          chk($sformatf("b_write%0d", i), 64'(got_b[i]), 64'({B_BASE + 32'(2 * i), mem_b[i]}));
      end
      repeat (5) @(negedge clock);
      chk("b_rom_reads", 64'(b_rd), 64'(B_COUNT));
      chk("b_done_held", 64'({b_done, b_cyc}), 64'({1'b1, 1'b0}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
